// File: rtl/gate_response_checker.sv
// Observing end of a 2-input gate test: handshake a vector, settle, compare out1, tally.
// Optional GATE_CHECK_STOP_ON_FAIL_EN ends the run on the first mismatch.
module gate_response_checker #(
   parameter int SETTLE_CYCLES = 7,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       func,
   input  logic             sample_valid,
   output logic             sample_ready,
   input  logic             in1,
   input  logic             in2,
   input  logic             out1,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [3:0]       coverage,
   output logic             fail_seen,
   output logic [1:0]       last_fail_vec
);
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, ARMED, SETTLE, CHECK, DONE} state_t;

   state_t         state, nstate;
   logic [1:0]     func_q;
   logic [1:0]     vec;
   logic [CW-1:0]  cnt;
   logic           exp_out;
   logic           mism;
   logic [3:0]     cov_nxt;

   always_comb begin
      exp_out = 1'b0;
      case (func_q)
         2'b00: exp_out = vec[1] & vec[0];
         2'b01: exp_out = vec[1] | vec[0];
         2'b10: exp_out = vec[1] ^ vec[0];
         2'b11: exp_out = ~(vec[1] & vec[0]);
         default: exp_out = 1'b0;
      endcase
      mism    = (out1 != exp_out);
      cov_nxt = coverage | (4'b0001 << vec);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   // start overrides every state, including the CHECK update
   always_comb begin
      nstate = state;
      if (start) nstate = ARMED;
      else begin
         case (state)
            IDLE:   nstate = IDLE;
            ARMED:  if (sample_valid) nstate = SETTLE;
            SETTLE: if (cnt == '0) nstate = CHECK;
            CHECK: begin
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
               if (mism || cov_nxt == 4'b1111) nstate = DONE;
               else                            nstate = ARMED;
`else
               if (cov_nxt == 4'b1111) nstate = DONE;
               else                    nstate = ARMED;
`endif
            end
            DONE:    nstate = DONE;
            default: nstate = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         func_q        <= '0;
         vec           <= '0;
         cnt           <= '0;
         err_count     <= '0;
         coverage      <= '0;
         fail_seen     <= 1'b0;
         last_fail_vec <= '0;
      end else if (start) begin
         func_q        <= func;
         err_count     <= '0;
         coverage      <= '0;
         fail_seen     <= 1'b0;
         last_fail_vec <= '0;
      end else begin
         case (state)
            ARMED: if (sample_valid) begin
               vec <= {in1, in2};
               cnt <= CW'(SETTLE_CYCLES - 1);
            end
            SETTLE: if (cnt != '0) cnt <= cnt - CW'(1);
            CHECK: begin
               coverage <= cov_nxt;
               if (mism) begin
                  if (err_count != '1) err_count <= err_count + ERR_W'(1);
                  fail_seen     <= 1'b1;
                  last_fail_vec <= vec;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sample_ready = (state == ARMED);
      busy         = (state == ARMED) || (state == SETTLE) || (state == CHECK);
      done         = (state == DONE);
      pass         = done && (err_count == '0);
   end
endmodule
